// File: rtl/datapath_ctrl_if.sv
// datapath_ctrl_if
// Groups the instruction handshake and the datapath strobe bus of the
// control-step sequencer.
//   run      start request from the instruction source
//   instr    8-bit instruction: [7:6] opcode, [5:4] rx, [3:2] ry, [1:0] unused
//   reg_sig  register strobes, bit 5-2k = Rk_in, bit 4-2k = Rk_out
//   data_in  drive external data onto the bus
//   A_in     load ALU operand register A
//   G_in     load ALU result register G
//   G_out    drive G onto the bus
//   op       ALU operation select
//   busy     sequencer is executing an instruction
//   done     one-cycle pulse in the final step of an instruction
//   err      one-cycle pulse with done for an illegal register address
// The master modport is the instruction source; the slave modport is the
// sequencer itself.
interface datapath_ctrl_if;
  logic       run;
  logic [7:0] instr;
  logic [5:0] reg_sig;
  logic       data_in;
  logic       A_in;
  logic       G_in;
  logic       G_out;
  logic [1:0] op;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output run, instr,
    input  reg_sig, data_in, A_in, G_in, G_out, op, busy, done, err
  );

  modport slave (
    input  run, instr,
    output reg_sig, data_in, A_in, G_in, G_out, op, busy, done, err
  );
endinterface

// File: rtl/datapath_ctrl.sv
// datapath_ctrl
// Control-step sequencer for the 3-register, 3-bit bus datapath. Accepts one
// instruction per run/done handshake and walks the datapath through its
// control steps (LOAD, MOV: one step; ADD, SUB: three steps).
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     datapath_ctrl_if.slave: run/instr in, strobes and status out
// Outputs are registered: the next state and next latched instruction are
// decoded combinationally and captured on the same edge as the state, so each
// strobe is high for exactly the cycle the FSM spends in that step.
module datapath_ctrl #(
  parameter logic [1:0] ADD_OP = 2'b00,
  parameter logic [1:0] SUB_OP = 2'b01
) (
  input  logic            clk,
  input  logic            resetn,
  datapath_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  localparam logic [1:0] OPC_LOAD = 2'b00;
  localparam logic [1:0] OPC_MOV  = 2'b01;
  localparam logic [1:0] OPC_ADD  = 2'b10;

  state_t     state, next_state;

  // Only opcode, rx and ry are kept; instr[1:0] carries no meaning.
  logic [5:0] instr_q, instr_d;
  logic       unused_instr_bits;

  logic [5:0] reg_sig_d;
  logic       data_in_d, a_in_d, g_in_d, g_out_d;
  logic [1:0] op_d;
  logic       busy_d, done_d, err_d;

  logic [1:0] opc_d, rx_d, ry_d;
  logic [5:0] rx_in_mask, rx_out_mask, ry_out_mask;

  assign unused_instr_bits = ^bus.instr[1:0];

  // Register address 11 does not exist; ry only matters when it is read.
  function automatic logic is_illegal(input logic [5:0] ins);
    return (ins[3:2] == 2'b11) ||
           ((ins[5:4] != OPC_LOAD) && (ins[1:0] == 2'b11));
  endfunction

  // Next state and next latched instruction. A new instruction is only taken
  // from IDLE, so run and instr are ignored while busy.
  always_comb begin
    next_state = state;
    instr_d    = instr_q;
    unique case (state)
      IDLE: begin
        if (bus.run) begin
          next_state = T1;
          instr_d    = bus.instr[7:2];
        end
      end
      T1: begin
        if ((instr_q[5] == 1'b1) && !is_illegal(instr_q)) begin
          next_state = T2;
        end else begin
          next_state = IDLE;
        end
      end
      T2:      next_state = T3;
      T3:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobe decode for the step about to be entered. Register select masks
  // place Rk_in at bit 5-2k and Rk_out at bit 4-2k; an address of 3 shifts
  // the mask out entirely, but illegal instructions never use them anyway.
  always_comb begin
    opc_d       = instr_d[5:4];
    rx_d        = instr_d[3:2];
    ry_d        = instr_d[1:0];
    rx_in_mask  = 6'b100000 >> {rx_d, 1'b0};
    rx_out_mask = 6'b010000 >> {rx_d, 1'b0};
    ry_out_mask = 6'b010000 >> {ry_d, 1'b0};

    reg_sig_d = '0;
    data_in_d = 1'b0;
    a_in_d    = 1'b0;
    g_in_d    = 1'b0;
    g_out_d   = 1'b0;
    op_d      = 2'b00;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = (next_state != IDLE);

    unique case (next_state)
      T1: begin
        if (is_illegal(instr_d)) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (opc_d == OPC_LOAD) begin
          reg_sig_d = rx_in_mask;
          data_in_d = 1'b1;
          done_d    = 1'b1;
        end else if (opc_d == OPC_MOV) begin
          reg_sig_d = rx_in_mask | ry_out_mask;
          done_d    = 1'b1;
        end else begin
          reg_sig_d = rx_out_mask;
          a_in_d    = 1'b1;
        end
      end
      T2: begin
        reg_sig_d = ry_out_mask;
        g_in_d    = 1'b1;
        op_d      = (opc_d == OPC_ADD) ? ADD_OP : SUB_OP;
      end
      T3: begin
        reg_sig_d = rx_in_mask;
        g_out_d   = 1'b1;
        done_d    = 1'b1;
      end
      default: begin
        reg_sig_d = '0;
      end
    endcase
  end

  // State, latched instruction and registered outputs. Reset drops every
  // output at once, abandoning any instruction in flight without a done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      instr_q     <= '0;
      bus.reg_sig <= '0;
      bus.data_in <= 1'b0;
      bus.A_in    <= 1'b0;
      bus.G_in    <= 1'b0;
      bus.G_out   <= 1'b0;
      bus.op      <= 2'b00;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      state       <= next_state;
      instr_q     <= instr_d;
      bus.reg_sig <= reg_sig_d;
      bus.data_in <= data_in_d;
      bus.A_in    <= a_in_d;
      bus.G_in    <= g_in_d;
      bus.G_out   <= g_out_d;
      bus.op      <= op_d;
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      bus.err     <= err_d;
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl
// Self-checking bench for datapath_ctrl. A small behavioural datapath
// (three 3-bit registers, A, G and the shared bus) is driven by the
// sequencer's strobes; a reference model turns each accepted instruction into
// its list of expected control steps and applies the instruction's effect on
// the register file with plain arithmetic when it completes.
module tb_datapath_ctrl;

  localparam logic [1:0] ADD_OP = 2'b00;
  localparam logic [1:0] SUB_OP = 2'b01;

  logic clk = 1'b0;
  logic resetn;
  logic [2:0] ext_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  datapath_ctrl_if bus ();

  datapath_ctrl #(.ADD_OP(ADD_OP), .SUB_OP(SUB_OP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath driven by the strobes.
  logic [2:0] rf [3] = '{default: 3'b000};
  logic [2:0] a_reg = 3'b000;
  logic [2:0] g_reg = 3'b000;
  logic [2:0] dbus;

  always_comb begin
    dbus = 3'b000;
    if (bus.data_in)         dbus = ext_data;
    else if (bus.G_out)      dbus = g_reg;
    else if (bus.reg_sig[4]) dbus = rf[0];
    else if (bus.reg_sig[2]) dbus = rf[1];
    else if (bus.reg_sig[0]) dbus = rf[2];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bus.reg_sig[5 - 2 * k]) rf[k] <= dbus;
    end
    if (bus.A_in) a_reg <= dbus;
    if (bus.G_in) g_reg <= (bus.op == ADD_OP) ? a_reg + dbus : a_reg - dbus;
  end

  logic [14:0] outvec;
  assign outvec = {bus.reg_sig, bus.data_in, bus.A_in, bus.G_in, bus.G_out,
                   bus.op, bus.busy, bus.done, bus.err};

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] ins,
                               input logic [2:0] d);
    bus.run   = r;
    bus.instr = ins;
    ext_data  = d;
  endtask

  // Reference model: expected step vectors and the register file contents.
  logic [14:0] exp_q[$];
  logic [14:0] cur_exp = '0;
  bit          cur_idle = 1'b1;
  bit          pend_valid = 1'b0;
  logic [7:0]  pend_instr;
  logic [2:0]  pend_data;
  logic [2:0]  ref_rf [3] = '{default: 3'b000};

  function automatic logic [5:0] inMask(input logic [1:0] k);
    return 6'b000001 << (5 - 2 * int'(k));
  endfunction

  function automatic logic [5:0] outMask(input logic [1:0] k);
    return 6'b000001 << (4 - 2 * int'(k));
  endfunction

  function automatic logic [14:0] step(input logic [5:0] rs, input logic di,
      input logic ai, input logic gi, input logic go, input logic [1:0] op,
      input logic dn, input logic er);
    return {rs, di, ai, gi, go, op, 1'b1, dn, er};
  endfunction

  function automatic bit badAddr(input logic [7:0] ins);
    return (ins[5:4] == 2'd3) || ((ins[7:6] != 2'd0) && (ins[3:2] == 2'd3));
  endfunction

  task automatic pushSteps(input logic [7:0] ins);
    logic [1:0] opc, rx, ry;
    opc = ins[7:6];
    rx  = ins[5:4];
    ry  = ins[3:2];
    if (badAddr(ins)) begin
      exp_q.push_back(step(6'b0, 0, 0, 0, 0, 2'b00, 1, 1));
    end else if (opc == 2'd0) begin
      exp_q.push_back(step(inMask(rx), 1, 0, 0, 0, 2'b00, 1, 0));
    end else if (opc == 2'd1) begin
      exp_q.push_back(step(inMask(rx) | outMask(ry), 0, 0, 0, 0, 2'b00, 1, 0));
    end else begin
      exp_q.push_back(step(outMask(rx), 0, 1, 0, 0, 2'b00, 0, 0));
      exp_q.push_back(step(outMask(ry), 0, 0, 1, 0,
                           (opc == 2'd2) ? ADD_OP : SUB_OP, 0, 0));
      exp_q.push_back(step(inMask(rx), 0, 0, 0, 1, 2'b00, 1, 0));
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      cur_exp    = '0;
      cur_idle   = 1'b1;
      pend_valid = 1'b0;
    end else begin
      if (cur_exp[1] && pend_valid) begin
        if (!badAddr(pend_instr)) begin
          case (pend_instr[7:6])
            2'd0: ref_rf[pend_instr[5:4]] = pend_data;
            2'd1: ref_rf[pend_instr[5:4]] = ref_rf[pend_instr[3:2]];
            2'd2: ref_rf[pend_instr[5:4]] = ref_rf[pend_instr[5:4]] + ref_rf[pend_instr[3:2]];
            default: ref_rf[pend_instr[5:4]] = ref_rf[pend_instr[5:4]] - ref_rf[pend_instr[3:2]];
          endcase
        end
        pend_valid = 1'b0;
      end
      if (cur_idle && bus.run) begin
        pushSteps(bus.instr);
        pend_valid = 1'b1;
        pend_instr = bus.instr;
        pend_data  = ext_data;
      end
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
      else                  cur_exp = '0;
      cur_idle = (cur_exp == '0);
      #1;
      checkOutput("outputs", 32'(outvec), 32'(cur_exp));
      checkOutput("bus_excl", 32'($countones({bus.data_in, bus.G_out, bus.reg_sig[4],
                                              bus.reg_sig[2], bus.reg_sig[0]}) <= 1), 32'd1);
      if (cur_idle) begin
        checkOutput("regfile", 32'({rf[0], rf[1], rf[2]}),
                    32'({ref_rf[0], ref_rf[1], ref_rf[2]}));
      end
    end
  end

  task automatic runInstr(input logic [7:0] ins, input logic [2:0] d);
    @(negedge clk);
    applyStimulus(1'b1, ins, d);
    @(negedge clk);
    bus.run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] b2b [4];
  int         done_cyc [4];

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'b000);
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 32'(outvec), 32'd0);
    resetn = 1'b1;

    runInstr(8'b00_01_00_00, 3'b010);
    runInstr(8'b00_00_00_00, 3'b111);
    runInstr(8'b01_10_00_00, 3'b000);
    runInstr(8'b10_00_01_00, 3'b000);
    runInstr(8'b11_00_01_00, 3'b000);
    runInstr(8'b10_11_00_00, 3'b000);
    runInstr(8'b01_00_11_00, 3'b000);
    checkOutput("r0_after_sub", 32'(rf[0]), 32'(3'b111));

    // Reset during T2 of an ADD: outputs drop before the next edge.
    @(negedge clk);
    applyStimulus(1'b1, 8'b10_01_10_00, 3'b000);
    @(negedge clk);
    bus.run = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("reset_async", 32'(outvec), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back with run held high.
    b2b[0] = 8'b00_01_00_00;
    b2b[1] = 8'b00_10_00_00;
    b2b[2] = 8'b10_00_01_00;
    b2b[3] = 8'b01_01_10_00;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bit seen;
      seen = 1'b0;
      applyStimulus(1'b1, b2b[i], 3'b011);
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        if (bus.done) begin
          seen = 1'b1;
          done_cyc[i] = cyc;
        end
      end
      if (!seen) begin
        checkOutput("done_timeout", 32'd0, 32'd1);
        done_cyc[i] = 0;
      end
    end
    bus.run = 1'b0;
    checkOutput("spacing_load_load", 32'(done_cyc[1] - done_cyc[0]), 32'd2);
    checkOutput("spacing_load_add", 32'(done_cyc[2] - done_cyc[1]), 32'd4);
    checkOutput("spacing_add_mov", 32'(done_cyc[3] - done_cyc[2]), 32'd2);
    repeat (3) @(negedge clk);

    // Randomized traffic; data only changes while the sequencer is idle.
    repeat (400) begin
      @(negedge clk);
      bus.run   = ($urandom_range(0, 2) != 0);
      bus.instr = 8'($urandom);
      if (cur_idle) ext_data = 3'($urandom);
    end
    bus.run = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
